wb_copy_master: RTL and testbench
=================================

# wb_copy_master

Wishbone classic master that copies a block of 32-bit words from one slave address range to another, for example data BRAM to instruction BRAM or BRAM to the LED decoder. It attaches to a spare master port of `wb_conmax_top` (m2) and sits alongside the CPU's instruction and data masters. It is started by a one-cycle command pulse and reports completion, error and progress. The bus is driven one word at a time: a read, then a write, with a watchdog on every bus phase.

## Interface
- `LEN_W`, default 12: width of the word-count input; the maximum copy is 2^LEN_W−1 words.
- `TIMEOUT`, default 255: number of cycles a phase may wait for ack before it is aborted. 0 disables the watchdog.
- `wb_clk_i` input, 1: the only clock, rising edge.
- `wb_rst_i` input, 1: reset, asynchronous, active-high.
- `start_i` input, 1: one-cycle command pulse. Ignored while `busy_o`=1.
- `src_i` input, 32: source byte address. Bits [1:0] are ignored and forced to 0.
- `dst_i` input, 32: destination byte address. Bits [1:0] are ignored and forced to 0.
- `len_i` input, LEN_W: number of words to copy.
- `busy_o` output, 1: high from the cycle after an accepted start until the cycle `done_o` pulses.
- `done_o` output, 1: one-cycle pulse at completion or abort.
- `err_o` output, 1: sticky abort flag. Cleared by the next accepted start.
- `count_o` output, LEN_W: number of words fully written in the current or last job.
- `wb_adr_o` output, 32: bus address.
- `wb_dat_o` output, 32: write data.
- `wb_dat_i` input, 32: read data.
- `wb_sel_o` output, 4: always 4'b1111.
- `wb_we_o` output, 1: write enable.
- `wb_cyc_o` output, 1: bus cycle.
- `wb_stb_o` output, 1: strobe.
- `wb_ack_i` input, 1: slave acknowledge.
- `wb_err_i` input, 1: slave error.

## Operation
- All outputs are 0 after reset. The internal source address, destination address, remaining count, data buffer and watchdog are cleared. An assertion of reset mid-job drops cyc, stb and we immediately (asynchronously); no done pulse is generated.
- States and transitions:
  - IDLE: on start with len≠0, latch the addresses and length, clear `err_o` and `count_o`, go to RD. On start with len=0, clear err/count, go to FIN.
  - RD: cyc=stb=1, we=0, adr=src. On ack, capture `wb_dat_i` into the buffer, add 4 to src, go to WGAP.
  - WGAP: cyc=stb=0 for one cycle, then go to WR.
  - WR: cyc=stb=we=1, adr=dst, dat_o=buffer. On ack, add 4 to dst, increment count_o, decrement remaining. If remaining becomes 0 go to FIN, otherwise go to RGAP.
  - RGAP: cyc=stb=0 for one cycle, then go to RD.
  - FIN: done_o=1 and busy_o=0 for one cycle, then go to IDLE.
- Abort conditions, checked in RD or WR:
  - `wb_err_i`=1, or the watchdog reaching TIMEOUT cycles in the phase without ack.
  - On abort: set err_o, drop cyc/stb next cycle, go to FIN. The partial count_o is retained.
  - Abort takes priority over an ack in the same cycle.
- Address arithmetic is modulo 2^32. 0xFFFFFFFC + 4 wraps to 0x00000000 with no error.
- `wb_dat_o` holds the buffer value outside WR. `wb_adr_o` holds its last value when the bus is idle.
- A start pulse while busy is ignored. It is not queued.

## Timing
- Start is sampled on edge 0. RD drives the bus from cycle 1.
- The watchdog counts the cycles stb has been high in the current phase. It resets on entry to RD or WR.
- With a slave that acks on the 2nd stb cycle, each word takes 6 cycles: RD 2, gap 1, WR 2, gap 1. The final word has no trailing gap; FIN follows the last write ack.
- Latency from start to done for N words with a 2-cycle-ack slave is 6N cycles. len=0 gives done on cycle 1.
- Ack is sampled only while stb=1. A stray ack in a gap state or IDLE is ignored.

## Structure
- State encodings go in the shared `defines.v` include, next to `ZeroWord`, as `` `WCM_IDLE `` … `` `WCM_FIN ``, 3 bits.
- One sub-module, `wb_watchdog`: a counter with clear and enable inputs and TIMEOUT compare, output `expired`. It is bypassed when TIMEOUT=0.
- The FSM, address and count registers and data buffer stay in `wb_copy_master`.

## Test plan
- Basic copy: src=0x00000000, dst=0x10000000, len=3; the source holds 0xA1,0xB2,0xC3. Required: the destination receives the same three words in order at 0x10000000/04/08. done pulses at cycle 18, count_o=3, err_o=0, and stb is low for exactly one cycle between every phase.
- Zero length: len=0. Required: no cyc/stb ever asserted, done on cycle 1, count_o=0.
- Slave error: err_i is asserted during the 2nd write of len=4. Required: err_o=1, count_o=1, done pulses 1 cycle after the abort, no further bus cycles. A following start clears err_o.
- Watchdog: TIMEOUT=8 and the slave never acks the first read. Required: stb is high for 8 cycles then drops, err_o=1, count_o=0, done pulses.
- Address wrap plus busy start: src=0xFFFFFFFC, len=2. Required: the reads go to 0xFFFFFFFC then 0x00000000. A start pulse injected mid-job is ignored (no relatch, len stays 2).
- Reset mid-job: assert wb_rst_i during a WR phase of len=5. Required: cyc, stb, we, busy and done are 0 asynchronously, and the block is in IDLE after release.

Source files
------------

// File: rtl/wb_copy_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_copy_master_pkg
// Description : Shared state encoding and helpers for the Wishbone copy master.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_copy_master_pkg;

    typedef enum logic [2:0] {
        WCM_IDLE = 3'd0,
        WCM_RD   = 3'd1,
        WCM_WGAP = 3'd2,
        WCM_WR   = 3'd3,
        WCM_RGAP = 3'd4,
        WCM_FIN  = 3'd5
    } wcm_state_t;

    localparam logic [3:0]  c_sel_all   = 4'b1111;
    localparam logic [31:0] c_word_step = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_copy_master_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_copy_master_if
// Description : Wishbone classic bus bundle between the copy master and slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_copy_master_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_copy_master_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wb_watchdog
// Description : Per-phase ack watchdog; expires on the TIMEOUT-th enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic en,
    output logic      expired
);

    generate
        if (TIMEOUT == 0) begin : g_bypass
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, clk, rst, clr, en};
            assign expired     = 1'b0;
        end else begin : g_count
            localparam int c_cnt_w = $clog2(TIMEOUT + 1);
            logic [c_cnt_w-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (clr) begin
                    r_cnt <= '0;
                end else if (en) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            // r_cnt holds the number of earlier strobe cycles, so this flags the TIMEOUT-th one
            assign expired = en && (r_cnt == c_cnt_w'(TIMEOUT - 1));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_copy_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_copy_master
// Description : Wishbone classic master copying a block of words, one read then one write.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_copy_master
    import wb_copy_master_pkg::*;
#(
    parameter int LEN_W   = 12,
    parameter int TIMEOUT = 255
) (
    input  wire logic             wb_clk_i,
    input  wire logic             wb_rst_i,
    input  wire logic             start_i,
    input  wire logic [31:0]      src_i,
    input  wire logic [31:0]      dst_i,
    input  wire logic [LEN_W-1:0] len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [LEN_W-1:0]      count_o,
    wb_copy_master_if.master      bus
);

    wcm_state_t       r_state;
    wcm_state_t       w_next;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_adr;
    logic [31:0]      r_buf;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] r_count;
    logic             r_err;
    logic             w_phase;
    logic             w_expired;
    logic             w_abort;
    logic             w_ack;

    assign w_phase = (r_state == WCM_RD) || (r_state == WCM_WR);
    assign w_abort = w_phase && (bus.wb_err_i || w_expired);
    assign w_ack   = w_phase && bus.wb_ack_i;

    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (!w_phase),
        .en      (w_phase),
        .expired (w_expired)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= WCM_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WCM_IDLE: if (start_i) w_next = (len_i == '0) ? WCM_FIN : WCM_RD;
            WCM_RD: begin
                if (w_abort)    w_next = WCM_FIN;
                else if (w_ack) w_next = WCM_WGAP;
            end
            WCM_WGAP: w_next = WCM_WR;
            WCM_WR: begin
                if (w_abort)    w_next = WCM_FIN;
                else if (w_ack) w_next = (r_rem == LEN_W'(1)) ? WCM_FIN : WCM_RGAP;
            end
            WCM_RGAP: w_next = WCM_RD;
            WCM_FIN:  w_next = WCM_IDLE;
            default:  w_next = WCM_IDLE;
        endcase
    end

    // Address is loaded on phase entry so it holds steady through gaps and idle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_adr   <= '0;
            r_buf   <= '0;
            r_rem   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                WCM_IDLE: begin
                    if (start_i) begin
                        r_err   <= 1'b0;
                        r_count <= '0;
                        if (len_i != '0) begin
                            r_src <= word_align(src_i);
                            r_dst <= word_align(dst_i);
                            r_adr <= word_align(src_i);
                            r_rem <= len_i;
                        end
                    end
                end
                WCM_RD: begin
                    if (w_abort) begin
                        r_err <= 1'b1;
                    end else if (w_ack) begin
                        r_buf <= bus.wb_dat_i;
                        r_src <= r_src + c_word_step;
                    end
                end
                WCM_WGAP: r_adr <= r_dst;
                WCM_WR: begin
                    if (w_abort) begin
                        r_err <= 1'b1;
                    end else if (w_ack) begin
                        r_dst   <= r_dst + c_word_step;
                        r_count <= r_count + 1'b1;
                        r_rem   <= r_rem - 1'b1;
                    end
                end
                WCM_RGAP: r_adr <= r_src;
                default: ;
            endcase
        end
    end

    assign bus.wb_cyc_o = w_phase;
    assign bus.wb_stb_o = w_phase;
    assign bus.wb_we_o  = (r_state == WCM_WR);
    assign bus.wb_adr_o = r_adr;
    assign bus.wb_dat_o = r_buf;
    assign bus.wb_sel_o = c_sel_all;

    assign busy_o  = (r_state != WCM_IDLE) && (r_state != WCM_FIN);
    assign done_o  = (r_state == WCM_FIN);
    assign err_o   = r_err;
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_copy_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_copy_master
// Description : Randomized self-checking bench for wb_copy_master with a behavioural slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_copy_master;

    localparam int c_len_w   = 12;
    localparam int c_timeout = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [31:0]        src;
    logic [31:0]        dst;
    logic [c_len_w-1:0] len;
    logic               busy;
    logic               done;
    logic               err;
    logic [c_len_w-1:0] count;

    wb_copy_master_if bus ();

    always #5 clk = ~clk;

    wb_copy_master #(.LEN_W(c_len_w), .TIMEOUT(c_timeout)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .start_i  (start),
        .src_i    (src),
        .dst_i    (dst),
        .len_i    (len),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .count_o  (count),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural slave: source content is a pure function of address
    logic [31:0] seed;
    int          s_lat      = 2;
    bit          s_noack    = 1'b0;
    bit          s_err_en   = 1'b0;
    int          s_err_word = 0;
    bit          mon_clr    = 1'b0;
    int          s_cnt      = 0;
    int          s_wr_done  = 0;
    int          stb_hi     = 0;
    bit          cyc_seen   = 1'b0;
    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];
    logic [31:0] rd_adr_q[$];

    function automatic logic [31:0] src_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    assign bus.wb_dat_i = src_word(bus.wb_adr_o);
    assign bus.wb_ack_i = bus.wb_stb_o && !s_noack && (s_cnt == s_lat - 1);
    assign bus.wb_err_i = bus.wb_stb_o && bus.wb_we_o && s_err_en && (s_wr_done == s_err_word);

    always @(posedge clk) begin
        if (mon_clr) begin
            s_cnt     <= 0;
            s_wr_done <= 0;
            stb_hi    <= 0;
            cyc_seen  <= 1'b0;
            wr_adr_q.delete();
            wr_dat_q.delete();
            rd_adr_q.delete();
        end else begin
            s_cnt <= bus.wb_stb_o ? s_cnt + 1 : 0;
            if (bus.wb_stb_o) stb_hi <= stb_hi + 1;
            if (bus.wb_cyc_o) cyc_seen <= 1'b1;
            if (bus.wb_stb_o && bus.wb_ack_i && !bus.wb_err_i) begin
                if (bus.wb_we_o) begin
                    wr_adr_q.push_back(bus.wb_adr_o);
                    wr_dat_q.push_back(bus.wb_dat_o);
                    s_wr_done <= s_wr_done + 1;
                end else begin
                    rd_adr_q.push_back(bus.wb_adr_o);
                end
            end
        end
    end

    // Issues one job; done_cyc counts cycles after the start-sampling edge (-1 on timeout)
    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n, input int lat,
                           input int inj, output int done_cyc);
        int busy_bad;
        busy_bad = 0;
        done_cyc = -1;
        s_lat    = lat;
        @(negedge clk);
        mon_clr = 1'b1;
        start   = 1'b1;
        src     = s;
        dst     = d;
        len     = c_len_w'(n);
        @(negedge clk);
        mon_clr = 1'b0;
        start   = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            if (c == inj) begin
                start = 1'b1;
                src   = $urandom;
                dst   = $urandom;
                len   = c_len_w'(7);
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cyc = c;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_during_job", 32'(busy_bad), 32'd0);
        @(negedge clk);
        chk("done_one_pulse", {31'd0, done}, 32'd0);
    endtask

    task automatic check_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                              input int n, input int lat, input int done_cyc);
        logic [31:0] sa;
        logic [31:0] da;
        sa = {s[31:2], 2'b00};
        da = {d[31:2], 2'b00};
        chk({tag, "/done_cycle"}, 32'(done_cyc), (n == 0) ? 32'd1 : 32'(n * (2 * lat + 2)));
        chk({tag, "/count"}, 32'(count), 32'(n));
        chk({tag, "/err"}, {31'd0, err}, 32'd0);
        chk({tag, "/stb_cycles"}, 32'(stb_hi), 32'(2 * lat * n));
        chk({tag, "/n_writes"}, 32'(wr_adr_q.size()), 32'(n));
        chk({tag, "/n_reads"}, 32'(rd_adr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_adr_q.size() && i < rd_adr_q.size(); i++) begin
            chk({tag, "/rd_adr"}, rd_adr_q[i], sa + 32'(4 * i));
            chk({tag, "/wr_adr"}, wr_adr_q[i], da + 32'(4 * i));
            chk({tag, "/wr_dat"}, wr_dat_q[i], src_word(sa + 32'(4 * i)));
        end
    endtask

    initial begin
        int          dc;
        int          n;
        int          lat;
        int          waited;
        logic [31:0] s;
        logic [31:0] d;

        seed  = $urandom;
        rst   = 1'b1;
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
        repeat (3) @(negedge clk);
        chk("rst/busy", {31'd0, busy}, 32'd0);
        chk("rst/done", {31'd0, done}, 32'd0);
        chk("rst/err", {31'd0, err}, 32'd0);
        chk("rst/count", 32'(count), 32'd0);
        chk("rst/bus_ctl", {29'd0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 32'd0);
        chk("rst/adr", bus.wb_adr_o, 32'd0);
        chk("rst/dat", bus.wb_dat_o, 32'd0);
        rst = 1'b0;

        run_job(32'h0000_0000, 32'h1000_0000, 3, 2, 0, dc);
        check_copy("basic", 32'h0000_0000, 32'h1000_0000, 3, 2, dc);
        chk("basic/sel", {28'd0, bus.wb_sel_o}, 32'hF);

        for (int j = 0; j < 8; j++) begin
            s   = $urandom;
            d   = $urandom;
            n   = $urandom_range(1, 6);
            lat = $urandom_range(1, 4);
            run_job(s, d, n, lat, 0, dc);
            check_copy("rand", s, d, n, lat, dc);
        end

        // Slave error on the second write: one word lands, abort after one WR cycle
        s_err_en   = 1'b1;
        s_err_word = 1;
        run_job(32'h0000_0100, 32'h2000_0000, 4, 2, 0, dc);
        s_err_en = 1'b0;
        chk("slverr/done_cycle", 32'(dc), 32'd11);
        chk("slverr/err", {31'd0, err}, 32'd1);
        chk("slverr/count", 32'(count), 32'd1);
        chk("slverr/n_writes", 32'(wr_adr_q.size()), 32'd1);
        chk("slverr/stb_cycles", 32'(stb_hi), 32'd7);
        repeat (3) @(negedge clk);
        chk("slverr/idle_bus", {31'd0, bus.wb_cyc_o}, 32'd0);

        run_job(32'h0000_0040, 32'h3000_0000, 0, 2, 0, dc);
        chk("zero/done_cycle", 32'(dc), 32'd1);
        chk("zero/count", 32'(count), 32'd0);
        chk("zero/err_cleared", {31'd0, err}, 32'd0);
        chk("zero/no_cyc", {31'd0, cyc_seen}, 32'd0);

        s_noack = 1'b1;
        run_job(32'h0000_0200, 32'h4000_0000, 3, 2, 0, dc);
        s_noack = 1'b0;
        chk("wdog/done_cycle", 32'(dc), 32'd9);
        chk("wdog/stb_cycles", 32'(stb_hi), 32'd8);
        chk("wdog/err", {31'd0, err}, 32'd1);
        chk("wdog/count", 32'(count), 32'd0);

        run_job(32'hFFFF_FFFC, 32'h5000_0000, 2, 2, 3, dc);
        check_copy("wrap", 32'hFFFF_FFFC, 32'h5000_0000, 2, 2, dc);

        // Reset asserted between edges during a write phase
        @(negedge clk);
        start = 1'b1;
        src   = 32'h0000_0300;
        dst   = 32'h6000_0000;
        len   = c_len_w'(5);
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (!bus.wb_we_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("rstmid/reached_wr", {31'd0, bus.wb_we_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid/async_ctl", {27'd0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid/idle", {30'd0, busy, done}, 32'd0);
        chk("rstmid/bus_idle", {31'd0, bus.wb_cyc_o}, 32'd0);
        run_job(32'h0000_0400, 32'h7000_0000, 1, 3, 0, dc);
        check_copy("post_rst", 32'h0000_0400, 32'h7000_0000, 1, 3, dc);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
